// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
//   Bundles the instruction fields, the ALU zero flag and every control output
//   exchanged between the multi-cycle control unit and the datapath.
//
//   Modports:
//     master : the control unit -- reads instruction fields and flag_zero,
//              drives mux selects, read/write enables and stage-enable pulses.
//     slave  : the datapath side -- the mirror image of master.
//
//   Signals:
//     InstructionType[1:0]  instruction type (00 R, 01 J, 10 I, 11 S)
//     FunctionCode[4:0]     function code within the type
//     StopBit               instruction bit 31, return-from-call request
//     flag_zero             ALU zero flag
//     sig_alu_op[2:0], sig_pc_src[1:0], sig_rb_src, sig_alu_src[1:0],
//     sig_rf_enable_write, sig_enable_data_memory_write,
//     sig_enable_data_memory_read, sig_write_back_data_select,
//     en_instruction_fetch, en_instruction_decode, en_execute
// -----------------------------------------------------------------------------
interface control_unit_if;
  logic [1:0] InstructionType;
  logic [4:0] FunctionCode;
  logic       StopBit;
  logic       flag_zero;

  logic [2:0] sig_alu_op;
  logic [1:0] sig_pc_src;
  logic       sig_rb_src;
  logic [1:0] sig_alu_src;
  logic       sig_rf_enable_write;
  logic       sig_enable_data_memory_write;
  logic       sig_enable_data_memory_read;
  logic       sig_write_back_data_select;
  logic       en_instruction_fetch;
  logic       en_instruction_decode;
  logic       en_execute;

  modport master (
    input  InstructionType, FunctionCode, StopBit, flag_zero,
    output sig_alu_op, sig_pc_src, sig_rb_src, sig_alu_src,
           sig_rf_enable_write, sig_enable_data_memory_write,
           sig_enable_data_memory_read, sig_write_back_data_select,
           en_instruction_fetch, en_instruction_decode, en_execute
  );

  modport slave (
    output InstructionType, FunctionCode, StopBit, flag_zero,
    input  sig_alu_op, sig_pc_src, sig_rb_src, sig_alu_src,
           sig_rf_enable_write, sig_enable_data_memory_write,
           sig_enable_data_memory_read, sig_write_back_data_select,
           en_instruction_fetch, en_instruction_decode, en_execute
  );
endinterface

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle control unit for the 32-bit RISC processor. Sequences each
//   instruction through FETCH, DECODE, EXECUTE, MEM and WB, emits one-cycle
//   stage-enable pulses, decodes type/function into datapath selects and picks
//   the next-PC source (using flag_zero for BEQ).
//
//   Ports:
//     clock    in  system clock, rising-edge active
//     reset_n  in  asynchronous active-low reset
//     bus      control_unit_if.master (instruction fields in, controls out)
//
//   Configuration macro:
//     CONTROL_UNIT_STOP_RETURN_EN  when defined, StopBit=1 on a non-jump,
//                                  non-taken instruction selects pc_src 11.
//                                  When undefined StopBit is ignored.
// -----------------------------------------------------------------------------
module control_unit (
  input  logic           clock,
  input  logic           reset_n,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_e;
  typedef enum logic [2:0] {CLS_NOP, CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_JUMP} cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic       rb_src;
    logic       wb_sel;
  } decode_t;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_J = 2'b01;
  localparam logic [1:0] TYPE_I = 2'b10;
  localparam logic [1:0] TYPE_S = 2'b11;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLR = 3'b101;

  localparam logic [1:0] SRC_SA   = 2'b00;
  localparam logic [1:0] SRC_BUSB = 2'b01;
  localparam logic [1:0] SRC_SIMM = 2'b10;
  localparam logic [1:0] SRC_UIMM = 2'b11;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
`ifdef CONTROL_UNIT_STOP_RETURN_EN
  localparam logic [1:0] PC_RETURN = 2'b11;
`endif

  localparam decode_t DEC_RESET = '{cls: CLS_NOP, alu_op: OP_AND, alu_src: SRC_BUSB,
                                    rb_src: 1'b0, wb_sel: 1'b0};

  state_e     state_q, state_d;
  logic       run_q;        // low until the first edge after reset release
  decode_t    dec_q, dec_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic       last_state;
`ifdef CONTROL_UNIT_STOP_RETURN_EN
  logic       stop_q;
`endif

  // Instruction decode from the raw fields; captured on the edge leaving FETCH
  // so the selects are stable from DECODE through the final state.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    dec_d = DEC_RESET;
    case (bus.InstructionType)
      TYPE_R: begin
        if (bus.FunctionCode <= 5'd3) begin
          dec_d.cls    = CLS_ALU;
          dec_d.alu_op = {1'b0, bus.FunctionCode[1:0]};  // AND, ADD, SUB, CMP
        end
      end
      TYPE_I: begin
        case (bus.FunctionCode)
          5'd0: begin dec_d.cls = CLS_ALU; dec_d.alu_op = OP_AND; dec_d.alu_src = SRC_UIMM; end
          5'd1: begin dec_d.cls = CLS_ALU; dec_d.alu_op = OP_ADD; dec_d.alu_src = SRC_SIMM; end
          5'd2: begin
            dec_d.cls     = CLS_LW;
            dec_d.alu_op  = OP_ADD;
            dec_d.alu_src = SRC_SIMM;
            dec_d.wb_sel  = 1'b1;
          end
          5'd3: begin
            dec_d.cls     = CLS_SW;
            dec_d.alu_op  = OP_ADD;
            dec_d.alu_src = SRC_SIMM;
            dec_d.rb_src  = 1'b1;
          end
          5'd4: begin
            dec_d.cls     = CLS_BEQ;
            dec_d.alu_op  = OP_SUB;
            dec_d.rb_src  = 1'b1;
          end
          default: dec_d = DEC_RESET;
        endcase
      end
      TYPE_J: begin
        if (bus.FunctionCode <= 5'd1) dec_d.cls = CLS_JUMP;
      end
      TYPE_S: begin
        if (bus.FunctionCode <= 5'd3) begin
          dec_d.cls     = CLS_ALU;
          dec_d.alu_op  = bus.FunctionCode[0] ? OP_SLR : OP_SLL;
          // Funcs 2/3 are the variable forms that shift by Rs2 on BusB.
          dec_d.alu_src = bus.FunctionCode[1] ? SRC_BUSB : SRC_SA;
        end
      end
      default: dec_d = DEC_RESET;
    endcase
  end

  // Stage sequencing; the path depends on the instruction class captured at
  // the end of FETCH.
  always_comb begin
    state_d = state_q;
    if (run_q) begin
      case (state_q)
        FETCH:   state_d = DECODE;
        DECODE:  state_d = (dec_q.cls inside {CLS_JUMP, CLS_NOP}) ? FETCH : EXECUTE;
        EXECUTE: begin
          case (dec_q.cls)
            CLS_ALU:        state_d = WB;
            CLS_LW, CLS_SW: state_d = MEM;
            default:        state_d = FETCH;
          endcase
        end
        MEM:     state_d = (dec_q.cls == CLS_LW) ? WB : FETCH;
        WB:      state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  assign last_state = run_q && (state_q != FETCH) && (state_d == FETCH);

  // Next-PC source, decided in the instruction's last state and held until the
  // next instruction ends. flag_zero is therefore sampled on the edge leaving
  // EXECUTE, which is BEQ's last state.
  always_comb begin
    pc_src_d = pc_src_q;
    if (last_state) begin
      if (dec_q.cls == CLS_JUMP)                     pc_src_d = PC_JUMP;
      else if (dec_q.cls == CLS_BEQ && bus.flag_zero) pc_src_d = PC_BRANCH;
`ifdef CONTROL_UNIT_STOP_RETURN_EN
      else if (stop_q)                               pc_src_d = PC_RETURN;
`endif
      else                                           pc_src_d = PC_SEQ;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      run_q    <= 1'b0;
      dec_q    <= DEC_RESET;
      pc_src_q <= PC_SEQ;
`ifdef CONTROL_UNIT_STOP_RETURN_EN
      stop_q   <= 1'b0;
`endif
    end else begin
      run_q    <= 1'b1;
      state_q  <= state_d;
      pc_src_q <= pc_src_d;
      if (run_q && state_q == FETCH) begin
        dec_q  <= dec_d;
`ifdef CONTROL_UNIT_STOP_RETURN_EN
        stop_q <= bus.StopBit;
`endif
      end
    end
  end

  // Enables come straight from the state register, gated by run_q so they are
  // all low during reset and drop the instant reset_n falls.
  assign bus.en_instruction_fetch         = run_q && (state_q == FETCH);
  assign bus.en_instruction_decode        = run_q && (state_q == DECODE);
  assign bus.en_execute                   = run_q && (state_q == EXECUTE);
  assign bus.sig_rf_enable_write          = run_q && (state_q == WB);
  assign bus.sig_enable_data_memory_read  = run_q && (state_q == MEM) && (dec_q.cls == CLS_LW);
  assign bus.sig_enable_data_memory_write = run_q && (state_q == MEM) && (dec_q.cls == CLS_SW);

  assign bus.sig_alu_op                 = dec_q.alu_op;
  assign bus.sig_alu_src                = dec_q.alu_src;
  assign bus.sig_rb_src                 = dec_q.rb_src;
  assign bus.sig_write_back_data_select = dec_q.wb_sel;
  assign bus.sig_pc_src                 = pc_src_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit: reset state, a table of hand-derived
//   instruction vectors, randomized instructions checked against a behavioural
//   model, and an asynchronous reset in the middle of SW's MEM stage.
// -----------------------------------------------------------------------------
module tb_control_unit;

  typedef struct {
    logic [1:0] t;
    logic [4:0] f;
    logic       s;
    logic       z;
    int         lat;      // cycles from FETCH to the last state inclusive
    bit         mem;      // path visits MEM
    bit         wbs;      // path visits WB
    logic [2:0] op;
    logic [1:0] src;
    logic       rb;
    logic       wb;
    logic [1:0] pc;
    bit         chk_sel;  // selects are defined for this instruction
  } vec_t;

`ifdef CONTROL_UNIT_STOP_RETURN_EN
  localparam logic [1:0] STOP_PC = 2'b11;
`else
  localparam logic [1:0] STOP_PC = 2'b00;
`endif

  // Stage codes used by the bench
  localparam int ST_F = 0, ST_D = 1, ST_E = 2, ST_M = 3, ST_W = 4;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;
  logic [1:0] prev_pc;

  control_unit_if bus ();

  control_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: instruction name first, then each control from the name.
  function automatic string mnem(input logic [1:0] t, input logic [4:0] f);
    string m;
    m = "NOP";
    case (t)
      2'b00: case (f) 0: m = "AND";  1: m = "ADD";  2: m = "SUB"; 3: m = "CMP"; default: ; endcase
      2'b10: case (f) 0: m = "ANDI"; 1: m = "ADDI"; 2: m = "LW";  3: m = "SW"; 4: m = "BEQ"; default: ; endcase
      2'b01: case (f) 0: m = "J";    1: m = "JAL"; default: ; endcase
      2'b11: case (f) 0: m = "SLL";  1: m = "SLR";  2: m = "SLLV"; 3: m = "SLRV"; default: ; endcase
      default: ;
    endcase
    return m;
  endfunction

  function automatic vec_t model(input logic [1:0] t, input logic [4:0] f,
                                 input logic s, input logic z);
    vec_t  v;
    string m;
    m = mnem(t, f);
    v.t = t; v.f = f; v.s = s; v.z = z;
    v.lat = 4; v.mem = 1'b0; v.wbs = 1'b1; v.chk_sel = 1'b1;
    case (m)
      "LW":             begin v.lat = 5; v.mem = 1'b1; end
      "SW":             begin v.lat = 4; v.mem = 1'b1; v.wbs = 1'b0; end
      "BEQ":            begin v.lat = 3; v.wbs = 1'b0; end
      "J", "JAL", "NOP": begin v.lat = 2; v.wbs = 1'b0; v.chk_sel = 1'b0; end
      default: ;
    endcase
    case (m)
      "ADD", "ADDI", "LW", "SW": v.op = 3'd1;
      "SUB", "BEQ":              v.op = 3'd2;
      "CMP":                     v.op = 3'd3;
      "SLL", "SLLV":             v.op = 3'd4;
      "SLR", "SLRV":             v.op = 3'd5;
      default:                   v.op = 3'd0;
    endcase
    case (m)
      "ANDI":             v.src = 2'b11;
      "ADDI", "LW", "SW": v.src = 2'b10;
      "SLL", "SLR":       v.src = 2'b00;
      default:            v.src = 2'b01;
    endcase
    v.rb = (m == "SW" || m == "BEQ");
    v.wb = (m == "LW");
    if (m == "J" || m == "JAL")  v.pc = 2'b10;
    else if (m == "BEQ" && z)    v.pc = 2'b01;
    else if (s)                  v.pc = STOP_PC;
    else                         v.pc = 2'b00;
    return v;
  endfunction

  // Called at a falling edge inside FETCH; returns at the falling edge inside
  // the following FETCH.
  task automatic run_vec(input vec_t v, input string tag);
    bus.InstructionType = v.t;
    bus.FunctionCode    = v.f;
    bus.StopBit         = v.s;
    bus.flag_zero       = v.z;
    for (int i = 0; i < v.lat; i++) begin
      int st;
      st = (i < 3) ? i : ((i == 3 && v.mem) ? ST_M : ST_W);
      check($sformatf("%s c%0d en_fetch", tag, i),  32'(bus.en_instruction_fetch),  32'(st == ST_F));
      check($sformatf("%s c%0d en_decode", tag, i), 32'(bus.en_instruction_decode), 32'(st == ST_D));
      check($sformatf("%s c%0d en_execute", tag, i), 32'(bus.en_execute),          32'(st == ST_E));
      check($sformatf("%s c%0d rf_write", tag, i),  32'(bus.sig_rf_enable_write),   32'(st == ST_W));
      check($sformatf("%s c%0d mem_read", tag, i),  32'(bus.sig_enable_data_memory_read),
            32'(st == ST_M && v.wbs));
      check($sformatf("%s c%0d mem_write", tag, i), 32'(bus.sig_enable_data_memory_write),
            32'(st == ST_M && !v.wbs));
      if (st == ST_F)
        check($sformatf("%s c%0d pc_src_hold", tag, i), 32'(bus.sig_pc_src), 32'(prev_pc));
      if (st != ST_F && v.chk_sel) begin
        check($sformatf("%s c%0d alu_op", tag, i),  32'(bus.sig_alu_op),  32'(v.op));
        check($sformatf("%s c%0d alu_src", tag, i), 32'(bus.sig_alu_src), 32'(v.src));
        check($sformatf("%s c%0d rb_src", tag, i),  32'(bus.sig_rb_src),  32'(v.rb));
        check($sformatf("%s c%0d wb_sel", tag, i),  32'(bus.sig_write_back_data_select), 32'(v.wb));
      end
      @(posedge clock);
      @(negedge clock);
    end
    check($sformatf("%s next en_fetch", tag), 32'(bus.en_instruction_fetch), 32'd1);
    check($sformatf("%s next pc_src", tag),   32'(bus.sig_pc_src),           32'(v.pc));
    prev_pc = v.pc;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " en_fetch"},   32'(bus.en_instruction_fetch),  32'd0);
    check({tag, " en_decode"},  32'(bus.en_instruction_decode), 32'd0);
    check({tag, " en_execute"}, 32'(bus.en_execute),            32'd0);
    check({tag, " rf_write"},   32'(bus.sig_rf_enable_write),   32'd0);
    check({tag, " mem_read"},   32'(bus.sig_enable_data_memory_read),  32'd0);
    check({tag, " mem_write"},  32'(bus.sig_enable_data_memory_write), 32'd0);
    check({tag, " pc_src"},     32'(bus.sig_pc_src),  32'd0);
    check({tag, " alu_op"},     32'(bus.sig_alu_op),  32'd0);
    check({tag, " alu_src"},    32'(bus.sig_alu_src), 32'd1);
    check({tag, " rb_src"},     32'(bus.sig_rb_src),  32'd0);
    check({tag, " wb_sel"},     32'(bus.sig_write_back_data_select), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t sw;

    vectors     = 0;
    miscompares = 0;
    prev_pc     = 2'b00;
    reset_n     = 1'b0;
    bus.InstructionType = 2'b00;
    bus.FunctionCode    = 5'd0;
    bus.StopBit         = 1'b0;
    bus.flag_zero       = 1'b0;

    //            t      f      s     z     lat mem wbs op    src    rb    wb    pc      chk
    vecs.push_back('{2'd0, 5'd1, 1'b0, 1'b0, 4, 0, 1, 3'd1, 2'b01, 1'b0, 1'b0, 2'b00,   1}); // ADD
    vecs.push_back('{2'd2, 5'd2, 1'b0, 1'b0, 5, 1, 1, 3'd1, 2'b10, 1'b0, 1'b1, 2'b00,   1}); // LW
    vecs.push_back('{2'd2, 5'd3, 1'b0, 1'b0, 4, 1, 0, 3'd1, 2'b10, 1'b1, 1'b0, 2'b00,   1}); // SW
    vecs.push_back('{2'd2, 5'd4, 1'b0, 1'b1, 3, 0, 0, 3'd2, 2'b01, 1'b1, 1'b0, 2'b01,   1}); // BEQ taken
    vecs.push_back('{2'd2, 5'd4, 1'b0, 1'b0, 3, 0, 0, 3'd2, 2'b01, 1'b1, 1'b0, 2'b00,   1}); // BEQ not taken
    vecs.push_back('{2'd1, 5'd1, 1'b1, 1'b0, 2, 0, 0, 3'd0, 2'b01, 1'b0, 1'b0, 2'b10,   0}); // JAL stop
    vecs.push_back('{2'd2, 5'd1, 1'b1, 1'b0, 4, 0, 1, 3'd1, 2'b10, 1'b0, 1'b0, STOP_PC, 1}); // ADDI stop
    vecs.push_back('{2'd0, 5'd0, 1'b0, 1'b0, 4, 0, 1, 3'd0, 2'b01, 1'b0, 1'b0, 2'b00,   1}); // AND
    vecs.push_back('{2'd0, 5'd2, 1'b0, 1'b1, 4, 0, 1, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00,   1}); // SUB, zero ignored
    vecs.push_back('{2'd0, 5'd3, 1'b0, 1'b0, 4, 0, 1, 3'd3, 2'b01, 1'b0, 1'b0, 2'b00,   1}); // CMP
    vecs.push_back('{2'd2, 5'd0, 1'b0, 1'b0, 4, 0, 1, 3'd0, 2'b11, 1'b0, 1'b0, 2'b00,   1}); // ANDI
    vecs.push_back('{2'd3, 5'd0, 1'b0, 1'b0, 4, 0, 1, 3'd4, 2'b00, 1'b0, 1'b0, 2'b00,   1}); // SLL
    vecs.push_back('{2'd3, 5'd1, 1'b0, 1'b0, 4, 0, 1, 3'd5, 2'b00, 1'b0, 1'b0, 2'b00,   1}); // SLR
    vecs.push_back('{2'd3, 5'd2, 1'b0, 1'b0, 4, 0, 1, 3'd4, 2'b01, 1'b0, 1'b0, 2'b00,   1}); // SLLV
    vecs.push_back('{2'd3, 5'd3, 1'b0, 1'b0, 4, 0, 1, 3'd5, 2'b01, 1'b0, 1'b0, 2'b00,   1}); // SLRV
    vecs.push_back('{2'd1, 5'd0, 1'b0, 1'b1, 2, 0, 0, 3'd0, 2'b01, 1'b0, 1'b0, 2'b10,   0}); // J
    vecs.push_back('{2'd0, 5'd7, 1'b0, 1'b0, 2, 0, 0, 3'd0, 2'b01, 1'b0, 1'b0, 2'b00,   0}); // NOP
    vecs.push_back('{2'd2, 5'd9, 1'b1, 1'b0, 2, 0, 0, 3'd0, 2'b01, 1'b0, 1'b0, STOP_PC, 0}); // NOP stop
    vecs.push_back('{2'd2, 5'd4, 1'b1, 1'b1, 3, 0, 0, 3'd2, 2'b01, 1'b1, 1'b0, 2'b01,   1}); // BEQ taken beats stop
    vecs.push_back('{2'd2, 5'd4, 1'b1, 1'b0, 3, 0, 0, 3'd2, 2'b01, 1'b1, 1'b0, STOP_PC, 1}); // BEQ not taken, stop

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_reset_state("reset");
    reset_n = 1'b1;
    #1;
    check("release en_fetch", 32'(bus.en_instruction_fetch), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("first en_fetch", 32'(bus.en_instruction_fetch), 32'd1);

    // Table vectors
    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Randomized instructions against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0] t;
      logic [4:0] f;
      t = 2'($urandom_range(0, 3));
      f = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      run_vec(model(t, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
              $sformatf("rnd%0d", i));
    end

    // Reset asserted during SW's MEM stage
    sw = model(2'd2, 5'd3, 1'b0, 1'b0);
    bus.InstructionType = sw.t;
    bus.FunctionCode    = sw.f;
    bus.StopBit         = sw.s;
    bus.flag_zero       = sw.z;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("midrst mem_write before", 32'(bus.sig_enable_data_memory_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("midrst async");
    @(negedge clock);
    reset_n = 1'b1;
    prev_pc = 2'b00;
    @(posedge clock);
    @(negedge clock);
    check("midrst restart en_fetch", 32'(bus.en_instruction_fetch), 32'd1);
    check("midrst restart mem_write", 32'(bus.sig_enable_data_memory_write), 32'd0);
    run_vec(model(2'd0, 5'd1, 1'b0, 1'b0), "post_rst ADD");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
